bus_wait_ctrl: RTL and testbench

- Bus-side companion of the cpu8080 core: decodes each bus cycle into the ROM/RAM chip selects and generates READY.
- Inserts a programmable number of wait states per region. Latches the cycle type and flags accesses to unmapped memory.
- Sits between the CPU address/status/strobe outputs and the rom8775/ram8156 CSn/READY pins in the system top.

---
 rtl/bus_wait_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_bus_wait_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_wait_ctrl.sv
// ---------------------------------------------------------------------------
// bus_wait_ctrl
//
// Bus-side companion of the cpu8080 core. It decodes each bus cycle into
// ROM/RAM chip selects, inserts a programmable number of wait states per
// region on READY, latches the cycle type, and records sticky error flags.
//
// State table
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | no cycle in progress, READY high, waiting for a strobe
//   ST_WAIT   | wait states being inserted, READY held low
//   ST_ACTIVE | wait states done, holding until both strobes return high
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous reset, active low
//   address_bus   in   CPU address [15:0]
//   IOMn          in   1 = I/O cycle, 0 = memory cycle
//   S0, S1        in   CPU status
//   RDn, WRn      in   read / write strobes, active low
//   rom_ready_in  in   READY from the ROM device
//   err_clr       in   synchronous clear of error flags and err_addr
//   rom_csn       out  ROM chip select, active low (combinational)
//   ram_csn       out  RAM chip select, active low (combinational)
//   ready         out  READY to the CPU
//   cycle_type    out  {IOMn,S1,S0} latched at cycle start
//   unmapped_err  out  sticky: memory cycle outside ROM and RAM
//   proto_err     out  sticky: RDn and WRn both low at a clock edge
//   err_addr      out  address of the first unmapped access
// ---------------------------------------------------------------------------
module bus_wait_ctrl #(
    parameter logic [7:0] ROM_PAGE = 8'h01,
    parameter logic [7:0] RAM_PAGE = 8'h00,
    parameter int unsigned ROM_WAIT = 2,
    parameter int unsigned RAM_WAIT = 0,
    parameter int unsigned UNM_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address_bus,
    input  logic        IOMn,
    input  logic        S0,
    input  logic        S1,
    input  logic        RDn,
    input  logic        WRn,
    input  logic        rom_ready_in,
    input  logic        err_clr,
    output logic        rom_csn,
    output logic        ram_csn,
    output logic        ready,
    output logic [2:0]  cycle_type,
    output logic        unmapped_err,
    output logic        proto_err,
    output logic [15:0] err_addr
);

    localparam logic [3:0] ROM_N = 4'(ROM_WAIT);
    localparam logic [3:0] RAM_N = 4'(RAM_WAIT);
    localparam logic [3:0] UNM_N = 4'(UNM_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       ready_q, ready_nxt;
    logic       rd_q, wr_q;

    logic       rom_hit, ram_hit;
    logic       start, strobe_idle;
    logic [3:0] region_wait;
    logic       unm_set, proto_set;

    // Region decode is purely combinational so the chip selects track the
    // address even while the block is held in reset.
    assign rom_hit = ~IOMn & (address_bus[15:8] == ROM_PAGE);
    assign ram_hit = ~IOMn & (address_bus[15:8] == RAM_PAGE);
    assign rom_csn = ~rom_hit;
    assign ram_csn = ~ram_hit;

    // A cycle starts on the first edge a strobe is seen low after both
    // strobes were high at the previous edge.
    assign start       = (~RDn | ~WRn) & rd_q & wr_q;
    assign strobe_idle = RDn & WRn;

    always_comb begin
        region_wait = UNM_N;
        if (rom_hit) begin
            region_wait = ROM_N;
        end else if (ram_hit) begin
            region_wait = RAM_N;
        end
    end

    assign unm_set   = start & ~IOMn & ~rom_hit & ~ram_hit;
    assign proto_set = ~RDn & ~WRn;

    // ROM device may stretch the cycle beyond the programmed wait states;
    // its READY is only honoured while ROM is selected.
    assign ready = ready_q & (rom_csn | rom_ready_in);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q <= 1'b1;
            wr_q <= 1'b1;
        end else begin
            rd_q <= RDn;
            wr_q <= WRn;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ready_q <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready_nxt = ready_q;
        case (state)
            ST_IDLE: begin
                ready_nxt = 1'b1;
                if (start) begin
                    if (region_wait == 4'd0) begin
                        state_nxt = ST_ACTIVE;
                    end else begin
                        cnt_nxt   = region_wait - 4'd1;
                        ready_nxt = 1'b0;
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // An aborted cycle (strobes back high) takes priority over
                // finishing the count.
                if (strobe_idle) begin
                    ready_nxt = 1'b1;
                    cnt_nxt   = 4'd0;
                    state_nxt = ST_IDLE;
                end else if (cnt == 4'd0) begin
                    ready_nxt = 1'b1;
                    state_nxt = ST_ACTIVE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_ACTIVE: begin
                ready_nxt = 1'b1;
                if (strobe_idle) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                ready_nxt = 1'b1;
                cnt_nxt   = 4'd0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_type <= 3'b000;
        end else if ((state == ST_IDLE) && start) begin
            cycle_type <= {IOMn, S1, S0};
        end
    end

    // Error capture: a new error in the same cycle as err_clr wins, and in
    // that case err_addr takes the new address even if a flag was pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            unmapped_err <= 1'b0;
            err_addr     <= 16'h0000;
        end else if (unm_set) begin
            unmapped_err <= 1'b1;
            if (!unmapped_err || err_clr) begin
                err_addr <= address_bus;
            end
        end else if (err_clr) begin
            unmapped_err <= 1'b0;
            err_addr     <= 16'h0000;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            proto_err <= 1'b0;
        end else if (proto_set) begin
            proto_err <= 1'b1;
        end else if (err_clr) begin
            proto_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_wait_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bus_wait_ctrl
//
// Self-checking bench for bus_wait_ctrl. Each bus cycle pushes its expected
// wait count, cycle type and chip selects onto a scoreboard queue; when the
// cycle completes the observed values are popped against it. Inputs change
// on the falling edge, outputs are sampled 1 ns after the falling edge.
// ---------------------------------------------------------------------------
module tb_bus_wait_ctrl;

    localparam int ROM_W = 2;
    localparam int RAM_W = 0;
    localparam int UNM_W = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] address_bus;
    logic        IOMn, S0, S1, RDn, WRn, rom_ready_in, err_clr;
    logic        rom_csn, ram_csn, ready, unmapped_err, proto_err;
    logic [2:0]  cycle_type;
    logic [15:0] err_addr;

    typedef struct packed {
        logic [7:0] low;
        logic [2:0] ct;
        logic       rcs;
        logic       mcs;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    bus_wait_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .address_bus  (address_bus),
        .IOMn         (IOMn),
        .S0           (S0),
        .S1           (S1),
        .RDn          (RDn),
        .WRn          (WRn),
        .rom_ready_in (rom_ready_in),
        .err_clr      (err_clr),
        .rom_csn      (rom_csn),
        .ram_csn      (ram_csn),
        .ready        (ready),
        .cycle_type   (cycle_type),
        .unmapped_err (unmapped_err),
        .proto_err    (proto_err),
        .err_addr     (err_addr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_wait(input logic [15:0] a, input logic iom);
        if (iom) return UNM_W;
        if (a[15:8] == 8'h01) return ROM_W;
        if (a[15:8] == 8'h00) return RAM_W;
        return UNM_W;
    endfunction

    // Counts falling edges with READY low after the start edge; releases
    // rom_ready_in once the programmed waits plus the stall have elapsed.
    task automatic measure_low(input int release_at, output int low, output bit done);
        low  = 0;
        done = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            err_clr = 1'b0;
            if (k == release_at) rom_ready_in = 1'b1;
            #1;
            if (ready) begin
                done = 1'b1;
                break;
            end
            low++;
        end
    endtask

    task automatic bus_cycle(input string name, input logic [15:0] addr, input logic iom,
                             input logic [1:0] s, input logic wr, input int stall,
                             input logic clr_at_start);
        exp_t e, got;
        int   n, low;
        bit   done;
        n     = model_wait(addr, iom);
        e.low = 8'(n + stall);
        e.ct  = {iom, s};
        e.rcs = ~(~iom & (addr[15:8] == 8'h01));
        e.mcs = ~(~iom & (addr[15:8] == 8'h00));
        sb_q.push_back(e);

        @(negedge clk);
        address_bus = addr;
        IOMn        = iom;
        {S1, S0}    = s;
        if (wr) WRn = 1'b0; else RDn = 1'b0;
        if (stall > 0) rom_ready_in = 1'b0;
        err_clr = clr_at_start;
        #1;
        got.rcs = rom_csn;
        got.mcs = ram_csn;
        measure_low(n + stall + 1, low, done);
        check_val({name, "_timeout"}, 32'(done), 32'd1);
        @(negedge clk);
        RDn = 1'b1;
        WRn = 1'b1;
        repeat (2) @(negedge clk);
        got.low = 8'(low);
        got.ct  = cycle_type;

        e = sb_q.pop_front();
        check_val({name, "_wait"},    32'(got.low), 32'(e.low));
        check_val({name, "_ctype"},   32'(got.ct),  32'(e.ct));
        check_val({name, "_rom_csn"}, 32'(got.rcs), 32'(e.rcs));
        check_val({name, "_ram_csn"}, 32'(got.mcs), 32'(e.mcs));
    endtask

    initial begin
        int  low;
        bit  done;
        rst          = 1'b0;
        address_bus  = 16'h0150;
        IOMn         = 1'b0;
        {S1, S0}     = 2'b00;
        RDn          = 1'b1;
        WRn          = 1'b1;
        rom_ready_in = 1'b1;
        err_clr      = 1'b0;

        #12;
        check_val("rst_ready",    32'(ready),        32'd1);
        check_val("rst_ctype",    32'(cycle_type),   32'd0);
        check_val("rst_unm",      32'(unmapped_err), 32'd0);
        check_val("rst_proto",    32'(proto_err),    32'd0);
        check_val("rst_err_addr", 32'(err_addr),     32'h0);
        check_val("rst_rom_csn",  32'(rom_csn),      32'd0);
        check_val("rst_ram_csn",  32'(ram_csn),      32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // RAM read, no waits; top-of-RAM write boundary
        bus_cycle("ram_rd", 16'h0042, 1'b0, 2'b10, 1'b0, 0, 1'b0);
        bus_cycle("ram_wr_ff", 16'h00FF, 1'b0, 2'b01, 1'b1, 0, 1'b0);
        // ROM opcode fetch, 2 waits; then the ROM stretching it 3 more
        bus_cycle("rom_fetch", 16'h0105, 1'b0, 2'b11, 1'b0, 0, 1'b0);
        bus_cycle("rom_stall", 16'h0105, 1'b0, 2'b10, 1'b0, 3, 1'b0);
        check_val("mapped_no_err", 32'(unmapped_err), 32'd0);

        // Unmapped accesses: first address is kept
        bus_cycle("unm_wr", 16'h3000, 1'b0, 2'b01, 1'b1, 0, 1'b0);
        check_val("unm_flag",  32'(unmapped_err), 32'd1);
        check_val("unm_addr1", 32'(err_addr),     32'h3000);
        bus_cycle("unm_rd", 16'h4000, 1'b0, 2'b10, 1'b0, 0, 1'b0);
        check_val("unm_addr2", 32'(err_addr),     32'h3000);
        // Clear coinciding with a new unmapped start: set wins, new address
        bus_cycle("unm_clr_set", 16'h5000, 1'b0, 2'b10, 1'b0, 0, 1'b1);
        check_val("clrset_flag", 32'(unmapped_err), 32'd1);
        check_val("clrset_addr", 32'(err_addr),     32'h5000);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        check_val("clr_flag", 32'(unmapped_err), 32'd0);
        check_val("clr_addr", 32'(err_addr),     32'h0);

        // I/O read: port on both address bytes would match ROM if memory
        bus_cycle("io_rd", 16'h0101, 1'b1, 2'b10, 1'b0, 0, 1'b0);
        check_val("io_no_unm", 32'(unmapped_err), 32'd0);

        // Reset in the middle of a ROM wait, strobe kept low throughout
        @(negedge clk);
        address_bus = 16'h0105;
        IOMn        = 1'b0;
        {S1, S0}    = 2'b11;
        RDn         = 1'b0;
        @(negedge clk);
        #1;
        check_val("midwait_low", 32'(ready), 32'd0);
        rst = 1'b0;
        #1;
        check_val("midwait_rst_ready", 32'(ready),      32'd1);
        check_val("midwait_rst_ctype", 32'(cycle_type), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        measure_low(0, low, done);
        check_val("fresh_timeout", 32'(done), 32'd1);
        check_val("fresh_wait",    32'(low),  32'(ROM_W));
        check_val("fresh_ctype",   32'(cycle_type), 32'b011);
        @(negedge clk);
        RDn = 1'b1;
        repeat (2) @(negedge clk);

        // Both strobes low together
        check_val("proto_pre", 32'(proto_err), 32'd0);
        address_bus = 16'h0010;
        RDn = 1'b0;
        WRn = 1'b0;
        @(negedge clk);
        RDn = 1'b1;
        WRn = 1'b1;
        #1;
        check_val("proto_set", 32'(proto_err), 32'd1);
        repeat (2) @(negedge clk);
        #1;
        check_val("proto_sticky", 32'(proto_err), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        check_val("proto_clr", 32'(proto_err), 32'd0);
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
